d_fifo_rr_arbiter: RTL

Round-robin arbiter that shares one D_FIFO-style write port between NUM_INPUTS valid/ready producers inside a CGRA processing element. It grants one requester at a time for a bounded burst of beats, then rotates. Each accepted beat is registered into a single output slot tagged with its source index. The output side connects directly to a FIFO's din / din_v / din_r.

---
 rtl/d_fifo_rr_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/d_fifo_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_INPUTS valid/ready
// producers; grants bounded bursts and registers each beat with its source tag.
module d_fifo_rr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_INPUTS = 4,
    parameter int MAX_BURST  = 4,
    parameter int SRC_W      = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]            in_valid,
    output logic [NUM_INPUTS-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [SRC_W-1:0]                 out_src,
    output logic                             out_valid,
    input  logic                             out_ready
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t                 state;
    logic [SRC_W-1:0]       ptr;
    logic [SRC_W-1:0]       grant;
    logic [7:0]             burst_cnt;

    logic                   slot_free;
    logic                   fire;
    logic                   last_beat;
    logic                   found_hi;
    logic                   found_lo;
    logic [SRC_W-1:0]       pick_hi;
    logic [SRC_W-1:0]       pick_lo;
    logic                   found;
    logic [SRC_W-1:0]       pick;
    logic [DATA_WIDTH-1:0]  grant_data;
    logic                   grant_valid;

    // Requesters above ptr win first; otherwise the lowest index wraps around.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        found_hi = 1'b0;
        found_lo = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (in_valid[i]) begin
                if (!found_hi && (i > int'(ptr))) begin
                    found_hi = 1'b1;
                    pick_hi  = SRC_W'(i);
                end
                if (!found_lo) begin
                    found_lo = 1'b1;
                    pick_lo  = SRC_W'(i);
                end
            end
        end
        found = found_hi | found_lo;
        pick  = found_hi ? pick_hi : pick_lo;
    end

    assign slot_free = ~out_valid | out_ready;

    always_comb begin
        grant_data  = '0;
        grant_valid = 1'b0;
        in_ready    = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant == SRC_W'(i)) begin
                grant_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                grant_valid = in_valid[i];
                in_ready[i] = (state == GRANT) && slot_free;
            end
        end
    end

    assign fire      = (state == GRANT) && grant_valid && slot_free;
    assign last_beat = (burst_cnt == 8'(MAX_BURST - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= SRC_W'(NUM_INPUTS - 1);
            grant     <= '0;
            burst_cnt <= '0;
            out_data  <= '0;
            out_src   <= '0;
            out_valid <= 1'b0;
        end else begin
            // NOTE: a load in the same cycle as a drain overwrites the slot and keeps it valid.
            if (fire) begin
                out_data  <= grant_data;
                out_src   <= grant;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= GRANT;
                        grant     <= pick;
                        burst_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (!grant_valid) begin
                        state <= IDLE;
                        ptr   <= grant;
                    end else if (fire) begin
                        burst_cnt <= burst_cnt + 8'd1;
                        if (last_beat) begin
                            state <= IDLE;
                            ptr   <= grant;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
